// File: rtl/fixed_to_float.sv
// rtl/fixed_to_float.sv - signed fixed-point to IEEE-754 single converter (iterative normaliser).
// Optional macro ROUND_NEAREST_EN: round-to-nearest-even when IN_W>24, truncation otherwise.
module fixed_to_float #(
    parameter int IN_W   = 32,
    parameter int FRAC_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_PACK = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Biased exponent stays within 64..190 over the legal parameter range.
    localparam logic [7:0] EXP_INIT = 8'(127 + IN_W - 1 - FRAC_W);

    logic [1:0]      state_q, state_d;
    logic            sign_q, sign_d;
    logic [IN_W-1:0] mag_q, mag_d;
    logic [7:0]      exp_q, exp_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_data_q, out_data_d;

    logic [IN_W-1:0] in_mag;
    logic [22:0]     mant_trunc;
    logic            round_up;
    logic [23:0]     mant_sum;
    logic [22:0]     mant_fin;
    logic [7:0]      exp_fin;

    // Negating the most negative input wraps to 2^(IN_W-1), which is the correct magnitude.
    assign in_mag = in_data[IN_W-1] ? ((~in_data) + {{(IN_W-1){1'b0}}, 1'b1}) : in_data;

    generate
        if (IN_W >= 24) begin : g_mant_wide
            assign mant_trunc = mag_q[IN_W-2 -: 23];
        end else begin : g_mant_narrow
            assign mant_trunc = {mag_q[IN_W-2:0], {(24-IN_W){1'b0}}};
        end
    endgenerate

`ifdef ROUND_NEAREST_EN
    generate
        if (IN_W > 25) begin : g_round_wide
            assign round_up = mag_q[IN_W-25] && ((|mag_q[IN_W-26:0]) || mant_trunc[0]);
        end else if (IN_W == 25) begin : g_round_one
            assign round_up = mag_q[0] && mant_trunc[0];
        end else begin : g_round_exact
            assign round_up = 1'b0;
        end
    endgenerate
`else
    assign round_up = 1'b0;
`endif

    // A mantissa carry-out leaves the low 23 bits zero and bumps the exponent.
    assign mant_sum = {1'b0, mant_trunc} + {23'd0, round_up};
    assign mant_fin = mant_sum[22:0];
    assign exp_fin  = exp_q + {7'd0, mant_sum[23]};

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    sign_d = in_data[IN_W-1];
                    mag_d  = in_mag;
                    exp_d  = EXP_INIT;
                    if (in_mag == '0) begin
                        sign_d     = 1'b0;
                        out_data_d = 32'h0000_0000;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_NORM;
                    end
                end
            end
            S_NORM: begin
                if (mag_q[IN_W-1]) begin
                    state_d = S_PACK;
                end else begin
                    mag_d = {mag_q[IN_W-2:0], 1'b0};
                    exp_d = exp_q - 8'd1;
                end
            end
            S_PACK: begin
                out_data_d  = {sign_q, exp_fin, mant_fin};
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                // Zero inputs enter DONE straight from IDLE; valid follows one cycle later.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            exp_q       <= 8'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0000_0000;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_fixed_to_float.sv
// tb/tb_fixed_to_float.sv - randomized and directed self-checking bench for fixed_to_float.
module tb_fixed_to_float;
    localparam int IN_W   = 32;
    localparam int FRAC_W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [IN_W-1:0] in_data = '0;
    logic            in_ready;
    logic            out_valid;
    logic [31:0]     out_data;
    logic            busy;

    int checks = 0;
    int errors = 0;

    fixed_to_float #(.IN_W(IN_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: value = x / 2^FRAC_W expressed as sign * 1.m * 2^(e-127).
    function automatic logic [31:0] model_float(input logic [IN_W-1:0] x, output int lat);
        longint v, mag, m, rem, half;
        int p, e;
        v = longint'($signed(x));
        mag = (v < 0) ? -v : v;
        if (mag == 0) begin
            lat = 1;
            return 32'h0000_0000;
        end
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        lat = (IN_W - 1 - p) + 2;
        e = 127 + p - FRAC_W;
        if (p <= 23) begin
            m = mag << (23 - p);
        end else begin
            m = mag >> (p - 23);
            rem = mag - (m << (p - 23));
            half = longint'(1) << (p - 24);
`ifdef ROUND_NEAREST_EN
            if (rem > half || (rem == half && m[0])) m = m + 1;
            if (m == (longint'(1) << 24)) begin
                m = longint'(1) << 23;
                e = e + 1;
            end
`else
            if (rem > half) m = m + 0;
`endif
        end
        return {(v < 0), e[7:0], m[22:0]};
    endfunction

    // Transaction-level model of the handshake timing.
    logic        m_idle = 1'b1;
    logic        m_valid = 1'b0;
    logic        m_pending = 1'b0;
    logic [31:0] m_data = '0;
    logic [31:0] m_next = '0;
    longint      edge_cnt = 0;
    longint      m_due = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle    = 1'b1;
            m_valid   = 1'b0;
            m_pending = 1'b0;
        end else begin
            int lat;
            edge_cnt++;
            if (m_valid && out_ready) begin
                m_valid = 1'b0;
                m_idle  = 1'b1;
            end else if (m_idle && in_valid) begin
                m_idle    = 1'b0;
                m_next    = model_float(in_data, lat);
                m_due     = edge_cnt + lat;
                m_pending = 1'b1;
            end else if (m_pending && edge_cnt == m_due) begin
                m_pending = 1'b0;
                m_valid   = 1'b1;
                m_data    = m_next;
            end
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_idle);
        chk("busy", busy, !m_idle);
        chk("out_valid", out_valid, m_valid);
        if (m_valid) chk("out_data", out_data, m_data);
    end

    task automatic convert(input logic [31:0] x, input logic [31:0] expv, input int explat);
        int n;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = x;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 64'(n), 64'(explat));
        chk("lit_data", out_data, expv);
    endtask

    initial begin
        int lat;
        logic [31:0] hold;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("model_1p0", model_float(32'h0001_0000, lat), 32'h3F80_0000);
        chk("model_lat", 64'(lat), 64'd17);
        convert(32'h0001_0000, 32'h3F80_0000, 17);
        convert(32'hFFFF_0000, 32'hBF80_0000, 17);
        convert(32'h8000_0000, 32'hC700_0000, 2);
        convert(32'h0000_0000, 32'h0000_0000, 1);
        convert(32'h0003_0000, 32'h4040_0000, 16);
        convert(32'h0000_0001, 32'h3780_0000, 33);
`ifdef ROUND_NEAREST_EN
        convert(32'h7FFF_FFFF, 32'h4700_0000, 3);
`else
        convert(32'h7FFF_FFFF, 32'h46FF_FFFF, 3);
`endif

        // Backpressure in DONE with a stray in_valid pulse.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0001_0000;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 40 && !out_valid; i++) @(negedge clk);
        hold = out_data;
        chk("bp_data0", hold, 32'h3F80_0000);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in_data  = 32'h0005_0000;
            @(negedge clk);
            chk("bp_valid", out_valid, 1'b1);
            chk("bp_data", out_data, 32'h3F80_0000);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", out_valid, 1'b0);
        chk("bp_release_ready", in_ready, 1'b1);

        // Asynchronous reset while normalising.
        in_valid = 1'b1;
        in_data  = 32'h0000_0001;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        convert(32'h0003_0000, 32'h4040_0000, 16);

        // Randomized traffic, varying leading-zero count and sign.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] r;
            @(negedge clk);
            r = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) r = -r;
            if ($urandom_range(0, 15) == 0) r = 32'h8000_0000;
            if ($urandom_range(0, 15) == 0) r = 32'h0;
            in_data   = r;
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
